// File: rtl/pcctl_if.sv
// ============================================================================
//  Module : pcctl_if
//  Brief  : Fetch-PC / redirect bundle between pipeline and next-PC controller.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pcctl_if #(
    parameter int XLEN = 64
) ();
    logic            stall_i_pcctl;
    logic            if_ready_i_pcctl;
    logic            br_valid_i_pcctl;
    logic            br_taken_i_pcctl;
    logic [XLEN-1:0] br_target_i_pcctl;
    logic            jmp_valid_i_pcctl;
    logic [XLEN-1:0] jmp_target_i_pcctl;
    logic            trap_valid_i_pcctl;
    logic [XLEN-1:0] trap_target_i_pcctl;
    logic [XLEN-1:0] pc_o_pcctl;
    logic            pc_valid_o_pcctl;
    logic            flush_o_pcctl;
    logic            misalign_o_pcctl;
    logic [31:0]     br_cnt_o_pcctl;
    logic [31:0]     taken_cnt_o_pcctl;

    modport master (
        output stall_i_pcctl, if_ready_i_pcctl,
        output br_valid_i_pcctl, br_taken_i_pcctl, br_target_i_pcctl,
        output jmp_valid_i_pcctl, jmp_target_i_pcctl,
        output trap_valid_i_pcctl, trap_target_i_pcctl,
        input  pc_o_pcctl, pc_valid_o_pcctl, flush_o_pcctl, misalign_o_pcctl,
        input  br_cnt_o_pcctl, taken_cnt_o_pcctl
    );

    modport slave (
        input  stall_i_pcctl, if_ready_i_pcctl,
        input  br_valid_i_pcctl, br_taken_i_pcctl, br_target_i_pcctl,
        input  jmp_valid_i_pcctl, jmp_target_i_pcctl,
        input  trap_valid_i_pcctl, trap_target_i_pcctl,
        output pc_o_pcctl, pc_valid_o_pcctl, flush_o_pcctl, misalign_o_pcctl,
        output br_cnt_o_pcctl, taken_cnt_o_pcctl
    );
endinterface

`default_nettype wire

// File: rtl/pcctl.sv
// ============================================================================
//  Module : pcctl
//  Brief  : Next-PC / redirect controller with post-redirect flush sequencing.
//           Optional branch statistics counters enabled by PCCTL_STAT_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pcctl #(
    parameter int               XLEN         = 64,
    parameter logic [XLEN-1:0]  RESET_PC     = 64'h8000_0000,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic     clk_i_pcctl,
    input  logic     rst_n_i_pcctl,
    pcctl_if.slave   pc_bus
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]      r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [2:0]      r_flush_cnt, w_flush_cnt_nxt;
    logic            r_misalign, w_misalign_nxt;
    logic            w_pc_valid, w_flush;

    // Priority decode: a trap masks jump and branch, a jump masks branch.
    logic            w_trap, w_jmp_req, w_br_req, w_jmp_mis, w_br_mis, w_redirect;
    logic [XLEN-1:0] w_target;

    assign w_trap     = pc_bus.trap_valid_i_pcctl;
    assign w_jmp_req  = !w_trap && pc_bus.jmp_valid_i_pcctl;
    assign w_br_req   = !w_trap && !pc_bus.jmp_valid_i_pcctl &&
                        pc_bus.br_valid_i_pcctl && pc_bus.br_taken_i_pcctl;
    assign w_jmp_mis  = w_jmp_req && (pc_bus.jmp_target_i_pcctl[1:0] != 2'b00);
    assign w_br_mis   = w_br_req  && (pc_bus.br_target_i_pcctl[1:0]  != 2'b00);
    assign w_redirect = w_trap || (w_jmp_req && !w_jmp_mis) || (w_br_req && !w_br_mis);
    assign w_target   = w_trap    ? pc_bus.trap_target_i_pcctl :
                        w_jmp_req ? pc_bus.jmp_target_i_pcctl  :
                                    pc_bus.br_target_i_pcctl;

    always_ff @(posedge clk_i_pcctl or negedge rst_n_i_pcctl) begin
        if (!rst_n_i_pcctl) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_flush_cnt <= 3'd0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_misalign  <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_flush_cnt_nxt = r_flush_cnt;
        w_misalign_nxt  = 1'b0;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_redirect) begin
                    w_state_nxt     = S_FLUSH;
                    w_pc_nxt        = w_target;
                    w_flush_cnt_nxt = C_FLUSH_LOAD;
                end else if (w_jmp_mis || w_br_mis) begin
                    w_misalign_nxt  = 1'b1;
                end else if (pc_bus.if_ready_i_pcctl && !pc_bus.stall_i_pcctl) begin
                    w_pc_nxt        = r_pc + XLEN'(4);
                end
            end
            S_FLUSH: begin
                // Only traps survive the flush; branches/jumps here are squashed.
                if (w_trap) begin
                    w_pc_nxt        = pc_bus.trap_target_i_pcctl;
                    w_flush_cnt_nxt = C_FLUSH_LOAD;
                end else if (r_flush_cnt <= 3'd1) begin
                    w_state_nxt     = S_RUN;
                    w_flush_cnt_nxt = 3'd0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        w_pc_valid = 1'b0;
        w_flush    = 1'b0;
        case (r_state)
            S_RUN:   w_pc_valid = 1'b1;
            S_FLUSH: w_flush    = 1'b1;
            default: ;
        endcase
    end

    assign pc_bus.pc_o_pcctl       = r_pc;
    assign pc_bus.pc_valid_o_pcctl = w_pc_valid;
    assign pc_bus.flush_o_pcctl    = w_flush;
    assign pc_bus.misalign_o_pcctl = r_misalign;

`ifdef PCCTL_STAT_EN
    logic [31:0] r_br_cnt, r_taken_cnt;
    logic        w_br_count;

    // Branches masked by a same-cycle trap or jump are not counted.
    assign w_br_count = (r_state == S_RUN) && pc_bus.br_valid_i_pcctl &&
                        !w_trap && !pc_bus.jmp_valid_i_pcctl;

    always_ff @(posedge clk_i_pcctl or negedge rst_n_i_pcctl) begin
        if (!rst_n_i_pcctl) begin
            r_br_cnt    <= 32'd0;
            r_taken_cnt <= 32'd0;
        end else begin
            if (w_br_count && (r_br_cnt != 32'hFFFF_FFFF))
                r_br_cnt <= r_br_cnt + 32'd1;
            if (w_br_count && pc_bus.br_taken_i_pcctl && (r_taken_cnt != 32'hFFFF_FFFF))
                r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign pc_bus.br_cnt_o_pcctl    = r_br_cnt;
    assign pc_bus.taken_cnt_o_pcctl = r_taken_cnt;
`else
    assign pc_bus.br_cnt_o_pcctl    = 32'd0;
    assign pc_bus.taken_cnt_o_pcctl = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcctl.sv
// ============================================================================
//  Module : tb_pcctl
//  Brief  : Directed bench for pcctl with a cycle-level behavioural model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pcctl;
    localparam int          XLEN   = 64;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int          FC     = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_mis = 0;

    pcctl_if #(.XLEN(XLEN)) bus ();

    pcctl #(.XLEN(XLEN), .RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
        .clk_i_pcctl   (clk),
        .rst_n_i_pcctl (rst_n),
        .pc_bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: boot flag, bubbles still to emit, architectural PC, statistics.
    bit          m_boot = 1'b1;
    int          m_left = 0;
    logic [63:0] m_pc   = RST_PC;
    bit          m_mis  = 1'b0;
    bit          m_mis_n;
    logic [31:0] m_br   = 32'd0;
    logic [31:0] m_tk   = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot = 1'b1; m_left = 0; m_pc = RST_PC; m_mis = 1'b0; m_br = 0; m_tk = 0;
        end else begin
            m_mis_n = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_left > 0) begin
                if (bus.trap_valid_i_pcctl) begin
                    m_pc = bus.trap_target_i_pcctl; m_left = FC;
                end else begin
                    m_left = m_left - 1;
                end
            end else if (bus.trap_valid_i_pcctl) begin
                m_pc = bus.trap_target_i_pcctl; m_left = FC;
            end else if (bus.jmp_valid_i_pcctl) begin
                if (bus.jmp_target_i_pcctl % 4 != 0) m_mis_n = 1'b1;
                else begin m_pc = bus.jmp_target_i_pcctl; m_left = FC; end
            end else begin
`ifdef PCCTL_STAT_EN
                if (bus.br_valid_i_pcctl) begin
                    if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                    if (bus.br_taken_i_pcctl && m_tk != 32'hFFFF_FFFF) m_tk = m_tk + 1;
                end
`endif
                if (bus.br_valid_i_pcctl && bus.br_taken_i_pcctl) begin
                    if (bus.br_target_i_pcctl % 4 != 0) m_mis_n = 1'b1;
                    else begin m_pc = bus.br_target_i_pcctl; m_left = FC; end
                end else if (bus.if_ready_i_pcctl && !bus.stall_i_pcctl) begin
                    m_pc = m_pc + 64'd4;
                end
            end
            m_mis = m_mis_n;
        end
    end

    always @(negedge clk) begin
        check("pc",       bus.pc_o_pcctl, m_pc);
        check("pc_valid", 64'(bus.pc_valid_o_pcctl), 64'(!m_boot && m_left == 0));
        check("flush",    64'(bus.flush_o_pcctl), 64'(m_left > 0));
        check("misalign", 64'(bus.misalign_o_pcctl), 64'(m_mis));
        check("br_cnt",   64'(bus.br_cnt_o_pcctl), 64'(m_br));
        check("taken_cnt",64'(bus.taken_cnt_o_pcctl), 64'(m_tk));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.br_valid_i_pcctl   = 1'b0; bus.br_taken_i_pcctl = 1'b0;
        bus.jmp_valid_i_pcctl  = 1'b0; bus.trap_valid_i_pcctl = 1'b0;
    endtask

    function automatic logic [63:0] stat(input logic [63:0] v);
`ifdef PCCTL_STAT_EN
        return v;
`else
        return 64'd0 & v;
`endif
    endfunction

    initial begin
        bus.stall_i_pcctl = 1'b0; bus.if_ready_i_pcctl = 1'b1;
        bus.br_target_i_pcctl = 64'd0; bus.jmp_target_i_pcctl = 64'd0;
        bus.trap_target_i_pcctl = 64'd0;
        idle();
        #1 rst_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        rst_n = 1'b1;
        check("boot_valid", 64'(bus.pc_valid_o_pcctl), 64'd0);
        check("boot_pc", bus.pc_o_pcctl, 64'h8000_0000);
        tick(); check("seq0", bus.pc_o_pcctl, 64'h8000_0000);
        check("seq0_valid", 64'(bus.pc_valid_o_pcctl), 64'd1);
        tick(); check("seq1", bus.pc_o_pcctl, 64'h8000_0004);
        tick(); check("seq2", bus.pc_o_pcctl, 64'h8000_0008);

        bus.if_ready_i_pcctl = 1'b0;
        tick(); tick(); tick();
        check("notready_hold", bus.pc_o_pcctl, 64'h8000_0008);
        bus.if_ready_i_pcctl = 1'b1;
        tick(); check("ready_adv", bus.pc_o_pcctl, 64'h8000_000C);

        bus.br_valid_i_pcctl = 1'b1; bus.br_taken_i_pcctl = 1'b1;
        bus.br_target_i_pcctl = 64'h8000_0100;
        tick(); idle();
        check("br_flush1", 64'(bus.flush_o_pcctl), 64'd1);
        check("br_flush1_valid", 64'(bus.pc_valid_o_pcctl), 64'd0);
        tick(); check("br_flush2", 64'(bus.flush_o_pcctl), 64'd1);
        tick(); check("br_run_pc", bus.pc_o_pcctl, 64'h8000_0100);
        check("br_run_valid", 64'(bus.pc_valid_o_pcctl), 64'd1);
        check("br_cnt1", 64'(bus.br_cnt_o_pcctl), stat(64'd1));
        check("tk_cnt1", 64'(bus.taken_cnt_o_pcctl), stat(64'd1));

        bus.trap_valid_i_pcctl = 1'b1; bus.trap_target_i_pcctl = 64'h8000_0200;
        bus.br_valid_i_pcctl = 1'b1; bus.br_taken_i_pcctl = 1'b1;
        bus.br_target_i_pcctl = 64'h8000_0100;
        tick(); idle();
        check("trap_wins", bus.pc_o_pcctl, 64'h8000_0200);
        tick(); tick();
        check("trap_tk_same", 64'(bus.taken_cnt_o_pcctl), stat(64'd1));

        bus.jmp_valid_i_pcctl = 1'b1; bus.jmp_target_i_pcctl = 64'h8000_0102;
        tick(); idle();
        check("jmp_mis_pulse", 64'(bus.misalign_o_pcctl), 64'd1);
        check("jmp_mis_hold", bus.pc_o_pcctl, 64'h8000_0200);
        check("jmp_mis_noflush", 64'(bus.flush_o_pcctl), 64'd0);
        tick(); check("jmp_mis_end", 64'(bus.misalign_o_pcctl), 64'd0);
        check("jmp_mis_seq", bus.pc_o_pcctl, 64'h8000_0204);

        bus.br_valid_i_pcctl = 1'b1; bus.br_target_i_pcctl = 64'h8000_0301;
        tick(); idle();
        check("nt_seq", bus.pc_o_pcctl, 64'h8000_0208);
        check("nt_nomis", 64'(bus.misalign_o_pcctl), 64'd0);
        bus.br_valid_i_pcctl = 1'b1; bus.br_taken_i_pcctl = 1'b1;
        bus.br_target_i_pcctl = 64'h8000_0302;
        tick(); idle();
        check("br_mis_pulse", 64'(bus.misalign_o_pcctl), 64'd1);
        check("br_cnt3", 64'(bus.br_cnt_o_pcctl), stat(64'd3));
        check("tk_cnt2", 64'(bus.taken_cnt_o_pcctl), stat(64'd2));
        tick();
        bus.stall_i_pcctl = 1'b1;
        tick(); check("stall_hold", bus.pc_o_pcctl, 64'h8000_020C);
        bus.stall_i_pcctl = 1'b0;
        tick(); check("stall_rel", bus.pc_o_pcctl, 64'h8000_0210);

        bus.jmp_valid_i_pcctl = 1'b1; bus.jmp_target_i_pcctl = 64'h8000_0400;
        tick(); idle();
        bus.br_valid_i_pcctl = 1'b1; bus.br_taken_i_pcctl = 1'b1;
        bus.br_target_i_pcctl = 64'h8000_0500;
        tick(); idle();
        check("flush_br_ignored", bus.pc_o_pcctl, 64'h8000_0400);
        bus.trap_valid_i_pcctl = 1'b1; bus.trap_target_i_pcctl = 64'h8000_0600;
        tick(); idle();
        check("flush_trap_pc", bus.pc_o_pcctl, 64'h8000_0600);
        bus.br_valid_i_pcctl = 1'b1; bus.br_taken_i_pcctl = 1'b1;
        tick(); idle();
        check("flush_restart", 64'(bus.flush_o_pcctl), 64'd1);
        tick(); check("flush_trap_run", 64'(bus.pc_valid_o_pcctl), 64'd1);
        check("flush_trap_run_pc", bus.pc_o_pcctl, 64'h8000_0600);

        bus.trap_valid_i_pcctl = 1'b1; bus.trap_target_i_pcctl = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); idle();
        tick(); tick();
        check("wrap_top", bus.pc_o_pcctl, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); check("wrap_zero", bus.pc_o_pcctl, 64'd0);

        bus.jmp_valid_i_pcctl = 1'b1; bus.jmp_target_i_pcctl = 64'h8000_0700;
        tick(); idle();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", bus.pc_o_pcctl, 64'h8000_0000);
        check("async_rst_flush", 64'(bus.flush_o_pcctl), 64'd0);
        check("async_rst_valid", 64'(bus.pc_valid_o_pcctl), 64'd0);
        tick(); rst_n = 1'b1;
        tick(); check("post_rst_pc", bus.pc_o_pcctl, 64'h8000_0000);
        check("post_rst_valid", 64'(bus.pc_valid_o_pcctl), 64'd1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

`default_nettype wire
